sample_scheduler: RTL and testbench
===================================

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter DEFAULT_PERIOD, 32'd49_999, reset value of the period register (1 kHz sample rate at 50 MHz).
REQ-002 Parameter LED_DIV, 16'd1000, number of completed conversions per activity_led toggle.
REQ-003 Parameter OVR_WIDTH, 16, width of overrun_count.
REQ-004 input_clock  in  1  system clock, 50 MHz; the block uses only this clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  level; 1 = schedule conversions.
REQ-007 cfg_period  in  32  sample period minus one, in input_clock cycles.
REQ-008 cfg_load  in  1  one-cycle strobe; loads cfg_period.
REQ-009 conv_done  in  1  one-cycle pulse from the ADC SPI reader when a conversion frame completes.
REQ-010 overrun_clr  in  1  one-cycle strobe; clears overrun and overrun_count.
REQ-011 conv_start  out  1  one-cycle pulse requesting one ADC conversion frame.
REQ-012 state  out  2  current FSM state encoding.
REQ-013 overrun  out  1  sticky; a tick occurred while a conversion was outstanding.
REQ-014 overrun_count  out  OVR_WIDTH  saturating count of overrun events.
REQ-015 activity_led  out  1  toggles every LED_DIV completed conversions.

Function
REQ-016 The FSM SHALL have four states: OFF=2'b00, ARMED=2'b01, START=2'b10, ACTIVE=2'b11, and state SHALL equal the registered FSM state.
REQ-017 The 32-bit period counter SHALL be held at 0 in OFF; SHALL increment by 1 per cycle in ARMED, START and ACTIVE; SHALL wrap to 0 on the cycle it equals period_reg (a tick).
REQ-018 The tick period SHALL be exactly period_reg+1 cycles, independent of conv_done timing.
REQ-019 OFF -> ARMED when enable=1, with the counter at 0 after that edge; the first tick is the edge on which counter==period_reg.
REQ-020 ARMED -> START on a tick; START -> ACTIVE unconditionally after one cycle; ACTIVE -> ARMED on conv_done.
REQ-021 conv_start SHALL be 1 exactly while state==START (Moore, one cycle per start); consecutive starts are period_reg+1 cycles apart in steady state.
REQ-022 A tick in START or ACTIVE SHALL issue no conv_start, SHALL set overrun, and SHALL increment overrun_count, saturating at all-ones.
REQ-023 overrun_clr SHALL clear overrun and overrun_count on the next edge; if a tick overrun occurs in the same cycle, the set wins: overrun=1, count=1.
REQ-024 conv_done SHALL be ignored in OFF, ARMED and START (no state change, no LED count).
REQ-025 conv_done coinciding with a tick in ACTIVE SHALL go to START (not ARMED) with no overrun recorded.
REQ-026 enable=0 in ARMED or START SHALL go to OFF on the next edge; no conv_start SHALL be emitted after the exit edge.
REQ-027 enable=0 in ACTIVE SHALL remain in ACTIVE until conv_done, then go to OFF; ticks counted meanwhile still record overruns.
REQ-028 cfg_load SHALL write period_reg <= max(cfg_period, 1) and clear the counter to 0 on the same edge; that edge produces no tick.
REQ-029 cfg_load SHALL not change the FSM state; a conversion already in progress completes normally.
REQ-030 A 16-bit done counter SHALL increment on each accepted conv_done (in ACTIVE); on reaching LED_DIV-1 it SHALL wrap to 0 and toggle activity_led.

Reset
REQ-031 reset=1 SHALL asynchronously force: state=OFF, counter=0, period_reg=DEFAULT_PERIOD, conv_start=0, overrun=0, overrun_count=0, done counter=0, activity_led=0.
REQ-032 reset asserted mid-conversion SHALL abandon it; after release, the block behaves as from power-up, with no conv_start until enable is sampled.

Verification
REQ-033 Reset release, cfg_load with cfg_period=9, enable=1, conv_done 3 cycles after each conv_start -> conv_start pulses exactly 10 cycles apart; overrun stays 0.
REQ-034 cfg_period=4, conv_done withheld for 12 cycles after conv_start -> no extra conv_start; overrun=1, overrun_count=2; next start is on the first tick after conv_done.
REQ-035 overrun_clr asserted on the same cycle as an overrun tick -> overrun=1, overrun_count=1.
REQ-036 cfg_load with cfg_period=0 -> period_reg=1; conv_start every 2 cycles when conv_done returns in 1 cycle.
REQ-037 enable dropped during ACTIVE -> state stays 2'b11 until conv_done, then 2'b00; no further conv_start; enable dropped in ARMED -> 2'b00 next cycle.
REQ-038 LED_DIV=4, 8 completed conversions -> activity_led toggles twice (0->1->0); reset mid-ACTIVE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sample_scheduler.sv
// sample_scheduler: periodic ADC conversion scheduler with overrun tracking and an activity LED
module sample_scheduler #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49_999,
    parameter logic [15:0] LED_DIV        = 16'd1000,
    parameter int          OVR_WIDTH      = 16
) (
    input  logic                 input_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          cfg_period,
    input  logic                 cfg_load,
    input  logic                 conv_done,
    input  logic                 overrun_clr,
    output logic                 conv_start,
    output logic [1:0]           state,
    output logic                 overrun,
    output logic [OVR_WIDTH-1:0] overrun_count,
    output logic                 activity_led
);
    localparam logic [1:0] OFF    = 2'b00;
    localparam logic [1:0] ARMED  = 2'b01;
    localparam logic [1:0] START  = 2'b10;
    localparam logic [1:0] ACTIVE = 2'b11;
    localparam logic [OVR_WIDTH-1:0] OVR_ONE = {{(OVR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [31:0]          r_count;
    logic [31:0]          r_period;
    logic                 r_ovr;
    logic [OVR_WIDTH-1:0] r_ovr_cnt;
    logic [15:0]          r_done_cnt;
    logic                 r_led;

    logic                 w_run;
    logic                 w_tick;
    logic                 w_ovr_evt;
    logic                 w_done_ok;
    logic                 w_led_wrap;
    logic [1:0]           w_next_state;

    // A tick is the cycle the counter reaches the period; a reload edge never ticks
    always_comb begin
        w_run      = r_state != OFF;
        w_tick     = w_run && !cfg_load && (r_count == r_period);
        w_done_ok  = (r_state == ACTIVE) && conv_done;
        w_ovr_evt  = w_tick && ((r_state == START) || ((r_state == ACTIVE) && !conv_done));
        w_led_wrap = w_done_ok && (r_done_cnt == LED_DIV - 16'd1);
    end

    // Next-state logic; a finishing conversion that meets a tick restarts immediately
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            OFF:     w_next_state = enable ? ARMED : OFF;
            ARMED:   w_next_state = !enable ? OFF : (w_tick ? START : ARMED);
            START:   w_next_state = enable ? ACTIVE : OFF;
            default: w_next_state = !conv_done ? ACTIVE : (!enable ? OFF : (w_tick ? START : ARMED));
        endcase
    end

    // FSM state register
    always_ff @(posedge input_clock or posedge reset)
        if (reset) r_state <= OFF;
        else r_state <= w_next_state;

    // Period counter: idle at zero, free-runs while scheduling, restarts on tick or reload
    always_ff @(posedge input_clock or posedge reset)
        if (reset) r_count <= 32'd0;
        else r_count <= (!w_run || cfg_load || w_tick) ? 32'd0 : r_count + 32'd1;

    // Period register; a zero period is promoted to one so ticks stay two cycles apart
    always_ff @(posedge input_clock or posedge reset)
        if (reset) r_period <= DEFAULT_PERIOD;
        else if (cfg_load) r_period <= (cfg_period == 32'd0) ? 32'd1 : cfg_period;

    // Sticky overrun flag and saturating count; a new overrun beats a same-cycle clear
    always_ff @(posedge input_clock or posedge reset)
        if (reset) begin
            r_ovr     <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_ovr_evt) begin
            r_ovr     <= 1'b1;
            r_ovr_cnt <= overrun_clr ? OVR_ONE : ((&r_ovr_cnt) ? r_ovr_cnt : r_ovr_cnt + OVR_ONE);
        end else if (overrun_clr) begin
            r_ovr     <= 1'b0;
            r_ovr_cnt <= '0;
        end

    // Completed-conversion divider driving the activity LED
    always_ff @(posedge input_clock or posedge reset)
        if (reset) begin
            r_done_cnt <= 16'd0;
            r_led      <= 1'b0;
        end else if (w_done_ok) begin
            r_done_cnt <= w_led_wrap ? 16'd0 : r_done_cnt + 16'd1;
            r_led      <= r_led ^ w_led_wrap;
        end

    assign conv_start    = r_state == START;
    assign state         = r_state;
    assign overrun       = r_ovr;
    assign overrun_count = r_ovr_cnt;
    assign activity_led  = r_led;
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: directed scenarios checked against a tick-schedule model of the scheduler
module tb_sample_scheduler;
    localparam int    OVR_W   = 3;
    localparam longint OVR_MAX = (1 << OVR_W) - 1;
    localparam int    LED_D   = 4;
    localparam longint DEF_P  = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable, cfg_load, conv_done, overrun_clr;
    logic [31:0]      cfg_period;
    logic             conv_start, overrun, activity_led;
    logic [1:0]       state;
    logic [OVR_W-1:0] overrun_count;

    longint cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    sample_scheduler #(
        .DEFAULT_PERIOD(32'd7),
        .LED_DIV(16'd4),
        .OVR_WIDTH(OVR_W)
    ) dut (
        .input_clock(clk),
        .reset(rst),
        .enable(enable),
        .cfg_period(cfg_period),
        .cfg_load(cfg_load),
        .conv_done(conv_done),
        .overrun_clr(overrun_clr),
        .conv_start(conv_start),
        .state(state),
        .overrun(overrun),
        .overrun_count(overrun_count),
        .activity_led(activity_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model: ticks are scheduled as absolute edge numbers; the conversion is tracked as
    // "session on", "start pulse pending" and "conversion outstanding".
    bit     m_on, m_busy, m_pulse, m_ovr, m_run, m_tick, m_evt;
    longint m_cyc = 0, m_next = 0, m_per = DEF_P, m_oc = 0, m_dones = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 0; m_busy = 0; m_pulse = 0; m_ovr = 0;
            m_oc = 0; m_dones = 0; m_per = DEF_P; m_next = 0;
        end else begin
            m_cyc++;
            m_run  = m_on || m_busy || m_pulse;
            m_tick = m_run && !cfg_load && (m_cyc == m_next);
            m_evt  = m_tick && (m_pulse || (m_busy && !conv_done));
            if (cfg_load) m_per = (cfg_period == 0) ? 1 : longint'(cfg_period);
            if (cfg_load || m_tick || !m_run) m_next = m_cyc + m_per + 1;
            if (m_evt) begin
                m_ovr = 1;
                m_oc  = overrun_clr ? 1 : (m_oc < OVR_MAX ? m_oc + 1 : m_oc);
            end else if (overrun_clr) begin
                m_ovr = 0;
                m_oc  = 0;
            end
            if (m_pulse) begin
                m_pulse = 0; m_busy = enable; m_on = enable;
            end else if (m_busy) begin
                if (conv_done) begin
                    m_busy = 0; m_dones++; m_on = enable; m_pulse = enable && m_tick;
                end
            end else if (m_on) begin
                m_on = enable; m_pulse = enable && m_tick;
            end else m_on = enable;
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("m_conv_start", conv_start, m_pulse);
        chk("m_state", state, m_pulse ? 2 : m_busy ? 3 : m_on ? 1 : 0);
        chk("m_overrun", overrun, m_ovr);
        chk("m_overrun_count", overrun_count, m_oc);
        chk("m_activity_led", activity_led, (m_dones / LED_D) % 2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int budget, output longint s);
        for (int i = 0; i < budget && !conv_start; i++) step();
        chk("start_seen", conv_start, 1);
        s = cyc;
    endtask

    task automatic respond(input int n);
        repeat (n) step();
        conv_done = 1; step(); conv_done = 0;
    endtask

    longint t0, s1, s2, s3;

    initial begin
        rst = 1; enable = 0; cfg_period = 0; cfg_load = 0; conv_done = 0; overrun_clr = 0;
        repeat (2) step();
        rst = 0; step();
        chk("rst_state", state, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_count", overrun_count, 0);
        chk("rst_led", activity_led, 0);
        // period 10, quick completions
        cfg_period = 9; cfg_load = 1; step(); cfg_load = 0;
        enable = 1; step(); t0 = cyc;
        wait_start(40, s1);
        chk("first_start_delay", s1 - t0, 10);
        for (int k = 0; k < 2; k++) begin
            respond(3);
            wait_start(40, s2);
            chk("start_spacing_10", s2 - s1, 10);
            s1 = s2;
        end
        chk("p10_no_overrun", overrun, 0);
        respond(3);
        enable = 0; step();
        chk("armed_disable_off", state, 0);
        // period 5, late completion
        cfg_period = 4; cfg_load = 1; enable = 1; step(); cfg_load = 0;
        wait_start(40, s1);
        repeat (12) step();
        conv_done = 1; step(); conv_done = 0;
        chk("late_overrun", overrun, 1);
        chk("late_overrun_count", overrun_count, 2);
        chk("late_back_armed", state, 1);
        wait_start(40, s2);
        chk("late_next_start", s2 - s1, 15);
        // clear coinciding with an overrun tick, then a plain clear
        repeat (4) step();
        overrun_clr = 1; step(); overrun_clr = 0;
        chk("clr_vs_tick_overrun", overrun, 1);
        chk("clr_vs_tick_count", overrun_count, 1);
        overrun_clr = 1; step(); overrun_clr = 0;
        chk("clr_overrun", overrun, 0);
        chk("clr_count", overrun_count, 0);
        conv_done = 1; step(); conv_done = 0;
        wait_start(40, s3);
        chk("post_clear_start", s3 - s2, 10);
        // completion on the tick edge restarts without an overrun
        repeat (4) step();
        conv_done = 1; step(); conv_done = 0;
        chk("done_tick_restart", state, 2);
        chk("done_tick_no_overrun", overrun_count, 0);
        // saturation
        repeat (40) step();
        chk("sat_count", overrun_count, 7);
        chk("sat_overrun", overrun, 1);
        overrun_clr = 1; conv_done = 1; step(); overrun_clr = 0; conv_done = 0;
        chk("sat_cleared", overrun_count, 0);
        // period 0 promoted to 1, load leaves state alone
        cfg_period = 0; cfg_load = 1; step(); cfg_load = 0;
        chk("load_keeps_state", state, 1);
        wait_start(40, s1);
        for (int k = 0; k < 3; k++) begin
            step(); conv_done = 1; step(); conv_done = 0;
            wait_start(10, s2);
            chk("start_spacing_2", s2 - s1, 2);
            s1 = s2;
        end
        chk("p2_no_overrun", overrun, 0);
        // enable dropped during a conversion
        step(); enable = 0;
        repeat (6) step();
        chk("active_hold", state, 3);
        chk("active_hold_overrun", overrun, 1);
        conv_done = 1; step(); conv_done = 0;
        chk("active_done_off", state, 0);
        repeat (6) step();
        chk("off_no_start", conv_start, 0);
        // LED divider from a fresh reset with the default period
        overrun_clr = 1; step(); overrun_clr = 0;
        rst = 1; step(); step(); rst = 0;
        enable = 1; step();
        for (int k = 1; k <= 12; k++) begin
            wait_start(40, s1);
            respond(2); step();
            if (k == 4) chk("led_after_4", activity_led, 1);
            if (k == 8) chk("led_after_8", activity_led, 0);
            if (k == 12) chk("led_after_12", activity_led, 1);
        end
        // asynchronous reset in the middle of a conversion
        wait_start(40, s1);
        repeat (9) step();
        chk("pre_rst_overrun", overrun, 1);
        chk("pre_rst_state", state, 3);
        #3 rst = 1; #1;
        chk("async_state", state, 0);
        chk("async_conv_start", conv_start, 0);
        chk("async_overrun", overrun, 0);
        chk("async_count", overrun_count, 0);
        chk("async_led", activity_led, 0);
        #1 rst = 0;
        step(); t0 = cyc;
        wait_start(40, s1);
        chk("post_rst_default_period", s1 - t0, 8);
        enable = 0; step();
        chk("start_disable_off", state, 0);
        chk("start_disable_no_pulse", conv_start, 0);
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
